// File: rtl/riscv_pkg.sv
// Shared RV32 decode encodings: opcodes, immediate/result-source selects, ALU ops, ID/EX control bundle.
// Pure types and functions; no timing or backpressure of its own.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} res_src_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef struct packed {
    logic      valid;
    logic      illegal;
    logic      reg_write;
    logic      mem_write;
    logic      alu_src;
    logic      branch;
    logic      jump;
    res_src_e  result_src;
    alu_ctrl_e alu_control;
  } ctrl_t;

  // alu_op: 00 address add, 01 branch compare, 10 follow funct3/funct7
  function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op, input logic [2:0] funct3,
                                           input logic op5, input logic funct7_5);
    alu_ctrl_e res;
    res = ALU_ADD;
    case (alu_op)
      2'b01: res = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  res = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  res = ALU_SLT;
          3'b110:  res = ALU_OR;
          3'b111:  res = ALU_AND;
          default: res = ALU_ADD;
        endcase
      end
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// Integer register file, 2 async reads / 1 write on rising clk; x0 hardwired to zero.
// Reads are combinational; with BYPASS=1 a same-cycle write is forwarded to the read ports.
module reg_file_bypass #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int RIDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RIDX_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [RIDX_W-1:0] raddr1,
  input  logic [RIDX_W-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != '0) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '{default: '0};
    else      regs_q <= regs_d;
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
    if (BYPASS != 0) begin
      if (we && waddr == raddr1 && raddr1 != '0) rdata1 = wdata;
      if (we && waddr == raddr2 && raddr2 != '0) rdata2 = wdata;
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage + ID/EX register: control decode, regfile read, imm extend; 1-cycle latency.
// StallE holds, FlushE bubbles (flush wins); LoadUseHazD is flagged only, the hazard unit stalls.
module decode_stage_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int RIDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [RIDX_W-1:0] RdW,
  input  logic [XLEN-1:0]   ResultW,
  output logic              LoadUseHazD,
  output logic              ValidE,
  output logic              IllegalE,
  output logic              MemWriteE,
  output logic              ALUSrcE,
  output logic              RegWriteE,
  output logic              BranchE,
  output logic              JumpE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [RIDX_W-1:0] RdE,
  output logic [RIDX_W-1:0] Rs1E,
  output logic [RIDX_W-1:0] Rs2E
);

  logic [6:0]        opcode;
  logic [RIDX_W-1:0] rs1_dec, rs2_dec, rd_dec;
  logic [XLEN-1:0]   rd1_dec, rd2_dec, imm_dec;
  logic [1:0]        alu_op;
  logic              known, uses_rs2;
  imm_src_e          imm_src;
  ctrl_t             ctrl_dec;

  assign opcode  = InstrD[6:0];
  assign rs1_dec = InstrD[15 +: RIDX_W];
  assign rs2_dec = InstrD[20 +: RIDX_W];
  assign rd_dec  = InstrD[7 +: RIDX_W];

  reg_file_bypass #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS)) u_rf (
    .clk(clk), .rst(rst), .we(RegWriteW), .waddr(RdW), .wdata(ResultW),
    .raddr1(rs1_dec), .raddr2(rs2_dec), .rdata1(rd1_dec), .rdata2(rd2_dec)
  );

  always_comb begin
    ctrl_dec = '0;
    imm_src  = IMM_I;
    alu_op   = 2'b00;
    known    = 1'b1;
    case (opcode)
      OP_LW:  begin ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src = 1'b1; ctrl_dec.result_src = RES_MEM; end
      OP_SW:  begin ctrl_dec.mem_write = 1'b1; ctrl_dec.alu_src = 1'b1; imm_src = IMM_S; end
      OP_R:   begin ctrl_dec.reg_write = 1'b1; alu_op = 2'b10; end
      OP_I:   begin ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src = 1'b1; alu_op = 2'b10; end
      OP_BEQ: begin ctrl_dec.branch = 1'b1; imm_src = IMM_B; alu_op = 2'b01; end
      OP_JAL: begin
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.jump       = 1'b1;
        ctrl_dec.result_src = RES_PC4;
        imm_src             = IMM_J;
      end
      default: known = 1'b0;
    endcase
    ctrl_dec.alu_control = alu_decode(alu_op, InstrD[14:12], InstrD[5], InstrD[30]);
    if (!known) begin
      ctrl_dec         = '0;
      ctrl_dec.illegal = 1'b1;
    end
    ctrl_dec.valid = 1'b1;
    // Non-instructions still carry data, but nothing that changes architectural state.
    if (!ValidD) begin
      ctrl_dec.valid     = 1'b0;
      ctrl_dec.illegal   = 1'b0;
      ctrl_dec.reg_write = 1'b0;
      ctrl_dec.mem_write = 1'b0;
      ctrl_dec.branch    = 1'b0;
      ctrl_dec.jump      = 1'b0;
    end
  end

  always_comb begin
    case (imm_src)
      IMM_S:   imm_dec = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_dec = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J:   imm_dec = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_dec = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  ctrl_t             ctrl_q, ctrl_d;
  logic [XLEN-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d, pc4_q, pc4_d;
  logic [RIDX_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;

  always_comb begin
    ctrl_d = ctrl_q; rd1_d = rd1_q; rd2_d = rd2_q; imm_d = imm_q;
    pc_d   = pc_q;   pc4_d = pc4_q; rd_d  = rd_q;  rs1_d = rs1_q; rs2_d = rs2_q;
    if (FlushE) begin
      ctrl_d = '0; rd1_d = '0; rd2_d = '0; imm_d = '0;
      pc_d   = '0; pc4_d = '0; rd_d  = '0; rs1_d = '0; rs2_d = '0;
    end else if (!StallE) begin
      ctrl_d = ctrl_dec; rd1_d = rd1_dec; rd2_d = rd2_dec; imm_d = imm_dec;
      pc_d   = PCD;      pc4_d = PCPlus4D; rd_d = rd_dec;  rs1_d = rs1_dec; rs2_d = rs2_dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0; rd1_q <= '0; rd2_q <= '0; imm_q <= '0;
      pc_q   <= '0; pc4_q <= '0; rd_q  <= '0; rs1_q <= '0; rs2_q <= '0;
    end else begin
      ctrl_q <= ctrl_d; rd1_q <= rd1_d; rd2_q <= rd2_d; imm_q <= imm_d;
      pc_q   <= pc_d;   pc4_q <= pc4_d; rd_q  <= rd_d;  rs1_q <= rs1_d; rs2_q <= rs2_d;
    end
  end

  assign uses_rs2    = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);
  assign LoadUseHazD = ctrl_q.valid && (ctrl_q.result_src == RES_MEM) && (rd_q != '0) && ValidD &&
                       ((rd_q == rs1_dec) || ((rd_q == rs2_dec) && uses_rs2));

  assign ValidE      = ctrl_q.valid;
  assign IllegalE    = ctrl_q.illegal;
  assign MemWriteE   = ctrl_q.mem_write;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign RegWriteE   = ctrl_q.reg_write;
  assign BranchE     = ctrl_q.branch;
  assign JumpE       = ctrl_q.jump;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ctrl_q.alu_control;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ImmExtE     = imm_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc4_q;
  assign RdE         = rd_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: BYPASS=1 and BYPASS=0 instances share stimulus,
// plus an XLEN=64 / NREG=16 instance for the wide-datapath round trip.
module tb_decode_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, StallE, FlushE, ValidD, RegWriteW;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic [4:0]  RdW;

  // index 0: BYPASS=1, index 1: BYPASS=0
  logic        haz [2], vld [2], ill [2], mw [2], asrc [2], rw [2], br [2], jmp [2];
  logic [1:0]  rsrc [2];
  logic [2:0]  aluc [2];
  logic [31:0] rd1 [2], rd2 [2], imm [2], pce [2], pc4e [2];
  logic [4:0]  rde [2], rs1e [2], rs2e [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS(1 - g)) u_dut (
      .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD), .InstrD(InstrD),
      .PCD(PCD), .PCPlus4D(PCPlus4D), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .LoadUseHazD(haz[g]), .ValidE(vld[g]), .IllegalE(ill[g]), .MemWriteE(mw[g]),
      .ALUSrcE(asrc[g]), .RegWriteE(rw[g]), .BranchE(br[g]), .JumpE(jmp[g]),
      .ResultSrcE(rsrc[g]), .ALUControlE(aluc[g]), .RD1E(rd1[g]), .RD2E(rd2[g]),
      .ImmExtE(imm[g]), .PCE(pce[g]), .PCPlus4E(pc4e[g]), .RdE(rde[g]), .Rs1E(rs1e[g]), .Rs2E(rs2e[g])
    );
  end

  logic [63:0] w_pcd, w_pc4d, w_resw;
  logic [3:0]  w_rdw;
  logic        w_haz, w_vld, w_ill, w_mw, w_asrc, w_rw, w_br, w_jmp;
  logic [1:0]  w_rsrc;
  logic [2:0]  w_aluc;
  logic [63:0] w_rd1, w_rd2, w_imm, w_pce, w_pc4e;
  logic [3:0]  w_rde, w_rs1e, w_rs2e;

  decode_stage_pipe #(.XLEN(64), .NREG(16), .BYPASS(1)) u_wide (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD), .InstrD(InstrD),
    .PCD(w_pcd), .PCPlus4D(w_pc4d), .RegWriteW(RegWriteW), .RdW(w_rdw), .ResultW(w_resw),
    .LoadUseHazD(w_haz), .ValidE(w_vld), .IllegalE(w_ill), .MemWriteE(w_mw), .ALUSrcE(w_asrc),
    .RegWriteE(w_rw), .BranchE(w_br), .JumpE(w_jmp), .ResultSrcE(w_rsrc), .ALUControlE(w_aluc),
    .RD1E(w_rd1), .RD2E(w_rd2), .ImmExtE(w_imm), .PCE(w_pce), .PCPlus4E(w_pc4e),
    .RdE(w_rde), .Rs1E(w_rs1e), .Rs2E(w_rs2e)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    RegWriteW = 1'b1; RdW = a; ResultW = d;
    tick();
    RegWriteW = 1'b0;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2, input logic [4:0] rs1);
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2, input logic [4:0] rs1);
    return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  initial begin
    rst = 1'b0; StallE = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    ValidD = 1'b1; InstrD = enc_i(12'd5, 5'd1, 3'b000, 5'd6, 7'b0010011);
    PCD = 32'h44; PCPlus4D = 32'h48;
    w_pcd = '0; w_pc4d = '0; w_resw = '0; w_rdw = '0;
    repeat (2) tick();
    chk("rst_valid", 64'(vld[0]), 64'd0);
    chk("rst_regwrite", 64'(rw[0]), 64'd0);
    chk("rst_pc", 64'(pce[0]), 64'd0);
    chk("rst_imm", 64'(imm[0]), 64'd0);

    rst = 1'b1; ValidD = 1'b0;
    wr_reg(5'd3, 32'h11112222);
    chk("novalid_pc", 64'(pce[0]), 64'h44);
    chk("novalid_vld", 64'(vld[0]), 64'd0);
    chk("novalid_rw", 64'(rw[0]), 64'd0);
    wr_reg(5'd1, 32'h10);
    wr_reg(5'd5, 32'h55);

    // add x4,x3,x3 while writeback writes x3
    ValidD = 1'b1; InstrD = enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd4);
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hCAFE0001;
    tick();
    RegWriteW = 1'b0;
    chk("byp_rd1", 64'(rd1[0]), 64'hCAFE0001);
    chk("byp_rd2", 64'(rd2[0]), 64'hCAFE0001);
    chk("nobyp_rd1", 64'(rd1[1]), 64'h11112222);
    chk("add_rw", 64'(rw[0]), 64'd1);
    chk("add_rd", 64'(rde[0]), 64'd4);
    chk("add_vld", 64'(vld[0]), 64'd1);
    chk("add_alu", 64'(aluc[0]), 64'd0);
    tick();
    chk("nobyp_later", 64'(rd1[1]), 64'hCAFE0001);

    // x0 is never written nor forwarded
    InstrD = enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd4);
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFFFFFF;
    tick();
    RegWriteW = 1'b0;
    chk("x0_byp", 64'(rd1[0]), 64'd0);
    tick();
    chk("x0_store", 64'(rd2[0]), 64'd0);

    InstrD = enc_r(7'b0100000, 5'd1, 5'd3, 3'b000, 5'd4);
    tick();
    chk("sub_alu", 64'(aluc[0]), 64'd1);

    // addi x6,x1,5 then stall for three edges
    InstrD = enc_i(12'd5, 5'd1, 3'b000, 5'd6, 7'b0010011); PCD = 32'h80;
    tick();
    chk("addi_imm", 64'(imm[0]), 64'd5);
    chk("addi_rd1", 64'(rd1[0]), 64'h10);
    chk("addi_asrc", 64'(asrc[0]), 64'd1);
    StallE = 1'b1; InstrD = enc_s(12'd12, 5'd9, 5'd5); PCD = 32'h84;
    RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h99;
    tick();
    RegWriteW = 1'b0;
    repeat (2) tick();
    chk("stall_imm", 64'(imm[0]), 64'd5);
    chk("stall_rd", 64'(rde[0]), 64'd6);
    chk("stall_pc", 64'(pce[0]), 64'h80);
    chk("stall_mw", 64'(mw[0]), 64'd0);
    chk("stall_rw", 64'(rw[0]), 64'd1);
    FlushE = 1'b1;
    tick();
    chk("flush_vld", 64'(vld[0]), 64'd0);
    chk("flush_rw", 64'(rw[0]), 64'd0);
    chk("flush_rd", 64'(rde[0]), 64'd0);
    StallE = 1'b0; FlushE = 1'b0;
    tick();
    chk("sw_mw", 64'(mw[0]), 64'd1);
    chk("sw_imm", 64'(imm[0]), 64'd12);
    chk("sw_rd2", 64'(rd2[0]), 64'h99);
    chk("sw_rd1", 64'(rd1[0]), 64'h55);

    // load-use: lw x7 in Execute
    InstrD = enc_i(12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011);
    tick();
    chk("lw_rsrc", 64'(rsrc[0]), 64'd1);
    InstrD = enc_r(7'd0, 5'd1, 5'd7, 3'b000, 5'd8); #1;
    chk("haz_add_rs1", 64'(haz[0]), 64'd1);
    InstrD = enc_s(12'd0, 5'd1, 5'd7); #1;
    chk("haz_sw", 64'(haz[0]), 64'd1);
    InstrD = enc_r(7'd0, 5'd7, 5'd1, 3'b000, 5'd8); #1;
    chk("haz_add_rs2", 64'(haz[0]), 64'd1);
    InstrD = enc_i(12'd7, 5'd1, 3'b000, 5'd8, 7'b0010011); #1;
    chk("haz_addi_imm", 64'(haz[0]), 64'd0);
    InstrD = enc_j(21'd0, 5'd7); #1;
    chk("haz_jal", 64'(haz[0]), 64'd0);
    ValidD = 1'b0; InstrD = enc_r(7'd0, 5'd1, 5'd7, 3'b000, 5'd8); #1;
    chk("haz_novalid", 64'(haz[0]), 64'd0);
    ValidD = 1'b1;
    InstrD = enc_i(12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011);
    tick();
    InstrD = enc_r(7'd0, 5'd1, 5'd0, 3'b000, 5'd8); #1;
    chk("haz_lw_x0", 64'(haz[0]), 64'd0);

    InstrD = enc_b(13'h1FFC, 5'd2, 5'd1);
    tick();
    chk("beq_imm", 64'(imm[0]), 64'hFFFFFFFC);
    chk("beq_br", 64'(br[0]), 64'd1);
    chk("beq_alu", 64'(aluc[0]), 64'd1);
    InstrD = enc_j(21'd8, 5'd1);
    tick();
    chk("jal_imm", 64'(imm[0]), 64'd8);
    chk("jal_jmp", 64'(jmp[0]), 64'd1);
    chk("jal_rsrc", 64'(rsrc[0]), 64'd2);
    InstrD = 32'h00000073;
    tick();
    chk("ill_flag", 64'(ill[0]), 64'd1);
    chk("ill_vld", 64'(vld[0]), 64'd1);
    chk("ill_ctrl", 64'({rw[0], mw[0], br[0], jmp[0], asrc[0], rsrc[0], aluc[0]}), 64'd0);

    // asynchronous reset in the middle of a valid instruction
    InstrD = enc_r(7'd0, 5'd3, 5'd5, 3'b000, 5'd4);
    tick();
    chk("pre_rst_vld", 64'(vld[0]), 64'd1);
    rst = 1'b0; #1;
    chk("arst_vld", 64'(vld[0]), 64'd0);
    chk("arst_rd1", 64'(rd1[0]), 64'd0);
    chk("arst_pc", 64'(pce[0]), 64'd0);
    InstrD = enc_i(12'd0, 5'd5, 3'b010, 5'd2, 7'b0000011);
    #1 rst = 1'b1;
    tick();
    chk("rel_rsrc", 64'(rsrc[0]), 64'd1);
    chk("rel_vld", 64'(vld[0]), 64'd1);
    chk("rel_x5", 64'(rd1[0]), 64'd0);

    // 64-bit / 16-register instance
    ValidD = 1'b0; RegWriteW = 1'b1; RdW = 5'd0; w_rdw = 4'd15; w_resw = 64'hDEADBEEF_01234567;
    tick();
    RegWriteW = 1'b0; w_rdw = 4'd0;
    ValidD = 1'b1; InstrD = enc_r(7'd0, 5'd15, 5'd31, 3'b000, 5'd1); w_pcd = 64'h1_0000_0004;
    tick();
    chk("w_rd1", w_rd1, 64'hDEADBEEF_01234567);
    chk("w_rd2", w_rd2, 64'hDEADBEEF_01234567);
    chk("w_rs1e", 64'(w_rs1e), 64'd15);
    chk("w_pce", w_pce, 64'h1_0000_0004);
    InstrD = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011);
    tick();
    chk("w_imm", w_imm, 64'hFFFFFFFF_FFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
